// File: rtl/mem_test_pkg.sv
// Shared types and helpers for the march tester: state encoding, pass count
// and the expected-word generator used by both the write and compare paths.
package mem_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RD_LO,
        ST_RD_HI,
        ST_DONE
    } state_t;

    localparam int NUM_PASSES = 2;
    localparam int DEF_ADDR_W = 8;
    localparam int LAST_ADDR  = (1 << DEF_ADDR_W) - 1;

    // {a,a} is built at the real address width, then cut to 16 bits.
    function automatic logic [15:0] expected_word(
        input logic [15:0] addr,
        input int unsigned addr_w,
        input logic        pass_idx,
        input logic [15:0] seed
    );
        logic [31:0] pair;
        logic [15:0] word;
        pair = ({16'h0000, addr} << addr_w) | {16'h0000, addr};
        word = seed ^ pair[15:0];
        return pass_idx ? ~word : word;
    endfunction

endpackage

// File: rtl/mem_march_tester_if.sv
// Tester-to-RAM-wrapper bus: word address, control, write word and the
// byte-wide read-back selected by mem_read_byte_sel.
interface mem_march_tester_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_cs;
    logic              mem_rw;
    logic              mem_read_byte_sel;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_rdata_byte;

    modport master (
        output mem_addr, mem_cs, mem_rw, mem_read_byte_sel, mem_wdata,
        input  mem_rdata_byte
    );

    modport slave (
        input  mem_addr, mem_cs, mem_rw, mem_read_byte_sel, mem_wdata,
        output mem_rdata_byte
    );
endinterface

// File: rtl/mem_test_checker.sv
// Byte comparator with a saturating mismatch counter and first-failure capture.
module mem_test_checker #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              sample,
    input  logic [7:0]        rdata_byte,
    input  logic [7:0]        exp_byte,
    input  logic [ADDR_W-1:0] addr,
    input  logic              hi,
    input  logic              pass_idx,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_hi,
    output logic              first_err_pass
);

    logic mismatch;
    assign mismatch = sample && (rdata_byte != exp_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_hi    <= 1'b0;
            first_err_pass  <= 1'b0;
        end else if (clear) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_hi    <= 1'b0;
            first_err_pass  <= 1'b0;
        end else if (mismatch) begin
            if (err_count != '1)
                err_count <= err_count + ERR_W'(1);
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= addr;
                first_err_hi    <= hi;
                first_err_pass  <= pass_idx;
            end
        end
    end

endmodule

// File: rtl/mem_march_tester.sv
// Two-pass march BIST sequencer for the 256x16 block-RAM wrapper: writes a
// seeded pattern (then its complement) and reads every word back byte by byte.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ST_IDLE     | waiting for start, memory deselected
//   ST_WRITE    | one write per address, pattern for current pass
//   ST_RD_ISSUE | read issued, low byte not yet valid
//   ST_RD_LO    | low byte valid, compared this cycle
//   ST_RD_HI    | high byte valid, compared this cycle
//   ST_DONE     | test complete, done held until start/abort
module mem_march_tester
    import mem_test_pkg::*;
#(
    parameter int ADDR_W = $clog2(LAST_ADDR + 1),
    parameter int DATA_W = 16,
    parameter int ERR_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [15:0]          seed,
    mem_march_tester_if.master   mem,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 first_err_valid,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic                 first_err_hi,
    output logic                 first_err_pass
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic                pass_idx;
    logic [15:0]         seed_r;
    logic                cs_r;
    logic                rw_r;
    logic                sel_r;
    logic [DATA_W-1:0]   wdata_r;

    logic [15:0] exp_word;
    logic [7:0]  exp_byte;
    logic        start_ok;
    logic        sample;

    assign exp_word = expected_word(16'(addr), ADDR_W, pass_idx, seed_r);
    assign exp_byte = (state == ST_RD_HI) ? exp_word[15:8] : exp_word[7:0];
    assign start_ok = start && !abort && (state == ST_IDLE || state == ST_DONE);
    assign sample   = !abort && (state == ST_RD_LO || state == ST_RD_HI);

    assign mem.mem_addr          = addr;
    assign mem.mem_cs            = cs_r;
    assign mem.mem_rw            = rw_r;
    assign mem.mem_read_byte_sel = sel_r;
    assign mem.mem_wdata         = wdata_r;

    assign pass = done && (err_count == '0);

    // Memory drive is registered on the transition into each state, so the
    // next write word is computed from the address being moved to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr     <= '0;
            pass_idx <= 1'b0;
            seed_r   <= '0;
            cs_r     <= 1'b0;
            rw_r     <= 1'b0;
            sel_r    <= 1'b0;
            wdata_r  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            cs_r    <= 1'b0;
            rw_r    <= 1'b0;
            sel_r   <= 1'b0;
            wdata_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state    <= ST_WRITE;
                        addr     <= '0;
                        pass_idx <= 1'b0;
                        seed_r   <= seed;
                        cs_r     <= 1'b1;
                        rw_r     <= 1'b1;
                        sel_r    <= 1'b0;
                        wdata_r  <= expected_word(16'h0000, ADDR_W, 1'b0, seed);
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (addr == ADDR_LAST) begin
                        state   <= ST_RD_ISSUE;
                        addr    <= '0;
                        rw_r    <= 1'b0;
                        wdata_r <= '0;
                    end else begin
                        addr    <= addr + ADDR_W'(1);
                        wdata_r <= expected_word(16'(addr + ADDR_W'(1)), ADDR_W, pass_idx, seed_r);
                    end
                end
                ST_RD_ISSUE: state <= ST_RD_LO;
                ST_RD_LO: begin
                    state <= ST_RD_HI;
                    sel_r <= 1'b1;
                end
                ST_RD_HI: begin
                    sel_r <= 1'b0;
                    if (addr != ADDR_LAST) begin
                        state <= ST_RD_ISSUE;
                        addr  <= addr + ADDR_W'(1);
                    end else if (pass_idx != 1'(NUM_PASSES - 1)) begin
                        state    <= ST_WRITE;
                        addr     <= '0;
                        pass_idx <= 1'b1;
                        rw_r     <= 1'b1;
                        wdata_r  <= expected_word(16'h0000, ADDR_W, 1'b1, seed_r);
                    end else begin
                        state <= ST_DONE;
                        cs_r  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_r  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mem_test_checker #(
        .ADDR_W (ADDR_W),
        .ERR_W  (ERR_W)
    ) u_checker (
        .clk             (clk),
        .reset           (reset),
        .clear           (start_ok),
        .sample          (sample),
        .rdata_byte      (mem.mem_rdata_byte),
        .exp_byte        (exp_byte),
        .addr            (addr),
        .hi              (state == ST_RD_HI),
        .pass_idx        (pass_idx),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_hi    (first_err_hi),
        .first_err_pass  (first_err_pass)
    );

endmodule

// File: tb/tb_mem_march_tester.sv
// Scoreboard bench: expected write words and end-of-test status are queued at
// start and compared as the writes and the done level appear.
module tb_mem_march_tester;
    import mem_test_pkg::*;

    typedef struct {
        int         errs;
        logic       valid;
        logic [7:0] addr;
        logic       hi;
        logic       pidx;
    } result_t;

    typedef struct {
        result_t m;
        result_t s;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] seed;
    logic [15:0] stuck_mask;

    logic        busy, done, pass, fev, fehi, fepass;
    logic [15:0] err_count;
    logic [7:0]  feaddr;
    logic        busy4, done4, pass4, fev4, fehi4, fepass4;
    logic [3:0]  err4;
    logic [7:0]  feaddr4;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc;

    logic [15:0] wq[$];
    exp_t        rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_march_tester_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    mem_march_tester_if #(.ADDR_W(8), .DATA_W(16)) bus4 ();

    mem_march_tester #(.ADDR_W(8), .DATA_W(16), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
        .mem(bus.master), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_valid(fev), .first_err_addr(feaddr),
        .first_err_hi(fehi), .first_err_pass(fepass)
    );

    mem_march_tester #(.ADDR_W(8), .DATA_W(16), .ERR_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
        .mem(bus4.master), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_err_valid(fev4), .first_err_addr(feaddr4),
        .first_err_hi(fehi4), .first_err_pass(fepass4)
    );

    // Registered-word RAM; byte mux after the register so the high byte is
    // available the cycle after the low byte without a new issue.
    logic [15:0] mem [256];
    logic [15:0] word_q = 16'h0000;
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_wdata;
            else            word_q <= mem[bus.mem_addr] | stuck_mask;
        end
    end
    assign bus.mem_rdata_byte  = bus.mem_read_byte_sel ? word_q[15:8] : word_q[7:0];
    assign bus4.mem_rdata_byte = 8'hFF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_word(input int a, input int p, input logic [15:0] s);
        logic [7:0]  a8;
        logic [15:0] w;
        a8 = 8'(a);
        w  = s ^ {a8, a8};
        return (p != 0) ? ~w : w;
    endfunction

    function automatic result_t ref_run(input logic [15:0] s, input logic [15:0] mask, input logic force_ff);
        result_t     r;
        logic [15:0] w, rd;
        logic [7:0]  got, want;
        r.errs = 0; r.valid = 0; r.addr = '0; r.hi = 0; r.pidx = 0;
        for (int p = 0; p < NUM_PASSES; p++) begin
            for (int a = 0; a <= LAST_ADDR; a++) begin
                w  = ref_word(a, p, s);
                rd = force_ff ? 16'hFFFF : (w | mask);
                for (int h = 0; h < 2; h++) begin
                    got  = (h != 0) ? rd[15:8] : rd[7:0];
                    want = (h != 0) ? w[15:8]  : w[7:0];
                    if (got != want) begin
                        r.errs++;
                        if (!r.valid) begin
                            r.valid = 1'b1;
                            r.addr  = 8'(a);
                            r.hi    = 1'(h);
                            r.pidx  = 1'(p);
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_cs && bus.mem_rw) begin
            if (wq.size() == 0) check_eq("wq_empty", 32'd1, 32'd0);
            else check_eq("wdata", {16'h0, bus.mem_wdata}, {16'h0, wq.pop_front()});
        end
    end

    task automatic start_test(input logic [15:0] s, input logic [15:0] mask);
        exp_t e;
        @(negedge clk);
        stuck_mask = mask;
        seed  = s;
        start = 1'b1;
        wq.delete();
        for (int p = 0; p < NUM_PASSES; p++)
            for (int a = 0; a <= LAST_ADDR; a++)
                wq.push_back(ref_word(a, p, s));
        e.m = ref_run(s, mask, 1'b0);
        e.s = ref_run(s, 16'h0000, 1'b1);
        rq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        int   sat;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (rq.size() == 0) begin
            check_eq({tag, "_rq_empty"}, 32'd1, 32'd0);
            return;
        end
        e = rq.pop_front();
        if (!done) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, "_latency"}, 32'(cyc - start_cyc + 1), 32'd2049);
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check_eq({tag, "_errs"}, {16'h0, err_count}, 32'(e.m.errs));
        check_eq({tag, "_pass"}, {31'h0, pass}, {31'h0, e.m.errs == 0});
        check_eq({tag, "_fev"}, {31'h0, fev}, {31'h0, e.m.valid});
        check_eq({tag, "_feaddr"}, {24'h0, feaddr}, {24'h0, e.m.addr});
        check_eq({tag, "_fehi"}, {31'h0, fehi}, {31'h0, e.m.hi});
        check_eq({tag, "_fepass"}, {31'h0, fepass}, {31'h0, e.m.pidx});
        sat = (e.s.errs > 15) ? 15 : e.s.errs;
        check_eq({tag, "_done4"}, {31'h0, done4}, 32'd1);
        check_eq({tag, "_err4"}, {28'h0, err4}, 32'(sat));
        check_eq({tag, "_pass4"}, {31'h0, pass4}, {31'h0, sat == 0});
        check_eq({tag, "_wq_left"}, 32'(wq.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; abort = 1'b0; seed = 16'h0000; stuck_mask = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs", {31'h0, bus.mem_cs}, 32'd0);
        check_eq("rst_wdata", {16'h0, bus.mem_wdata}, 32'd0);
        check_eq("rst_busy", {31'h0, busy}, 32'd0);
        check_eq("rst_done", {31'h0, done}, 32'd0);
        check_eq("rst_pass", {31'h0, pass}, 32'd0);
        check_eq("rst_errs", {16'h0, err_count}, 32'd0);
        check_eq("rst_fev", {31'h0, fev}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Good memory, seed 0
        start_test(16'h0000, 16'h0000);
        wait_done("good");
        repeat (5) @(posedge clk);
        #1;
        check_eq("done_hold", {31'h0, done}, 32'd1);
        check_eq("pass_hold", {31'h0, pass}, 32'd1);

        // Bit 3 stuck at 1, restarted straight from DONE
        start_test(16'h0000, 16'h0008);
        wait_done("stuck3");

        // Abort at cycle 300, then a fresh seed
        start_test(16'h3C3C, 16'h0000);
        repeat (298) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_cycle", 32'(cyc - start_cyc + 1), 32'd300);
        check_eq("abort_busy", {31'h0, busy}, 32'd0);
        check_eq("abort_cs", {31'h0, bus.mem_cs}, 32'd0);
        check_eq("abort_done", {31'h0, done}, 32'd0);
        check_eq("abort_done4", {31'h0, done4}, 32'd0);
        wq.delete();
        rq.delete();
        start_test(16'hA5A5, 16'h0000);
        wait_done("after_abort");

        // start while busy is ignored
        start_test(16'h5A5A, 16'h0000);
        repeat (98) @(posedge clk);
        @(negedge clk);
        seed  = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed  = 16'h5A5A;
        check_eq("ign_busy", {31'h0, busy}, 32'd1);
        wait_done("ignored");

        // start and abort together: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy", {31'h0, busy}, 32'd0);
        check_eq("sa_done", {31'h0, done}, 32'd0);
        check_eq("sa_cs", {31'h0, bus.mem_cs}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("sa_idle", {31'h0, busy}, 32'd0);

        // Reset during RD_HI with errors already counted
        start_test(16'h0000, 16'h0008);
        n = 0;
        while (!(bus.mem_read_byte_sel && err_count != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rdhi_reached", {31'h0, bus.mem_read_byte_sel}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mrst_cs", {31'h0, bus.mem_cs}, 32'd0);
        check_eq("mrst_busy", {31'h0, busy}, 32'd0);
        check_eq("mrst_errs", {16'h0, err_count}, 32'd0);
        check_eq("mrst_fev", {31'h0, fev}, 32'd0);
        check_eq("mrst_feaddr", {24'h0, feaddr}, 32'd0);
        check_eq("mrst_sel", {31'h0, bus.mem_read_byte_sel}, 32'd0);
        wq.delete();
        rq.delete();
        @(negedge clk);
        reset = 1'b0;
        start_test(16'h1234, 16'h0000);
        wait_done("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
